// File: rtl/result_drain_pkg.sv
// Shared types and constants for the result_drain serializer and its set FIFO.
package result_drain_pkg;

    localparam int unsigned ACC_WIDTH_DEF = 9;
    localparam int unsigned ELEMS_PER_SET = 4;

    typedef logic [1:0] elem_idx_t;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

endpackage

// File: rtl/result_drain_fifo.sv
// Set storage for result_drain: DEPTH slots of one 2x2 result set each.
module result_drain_fifo
    import result_drain_pkg::*;
#(
    parameter int unsigned ACC_WIDTH = ACC_WIDTH_DEF,
    parameter int unsigned DEPTH     = 2,
    localparam int unsigned PTR_W    = $clog2(DEPTH),
    localparam int unsigned CNT_W    = $clog2(DEPTH + 1)
) (
    input  logic                                    clk,
    input  logic                                    rstn,
    input  logic                                    push,
    input  logic                                    pop,
    input  logic [ELEMS_PER_SET-1:0][ACC_WIDTH-1:0] wr_set,
    output logic [ELEMS_PER_SET-1:0][ACC_WIDTH-1:0] head_set,
    output logic [ELEMS_PER_SET-1:0][ACC_WIDTH-1:0] next_set,
    output logic                                    full,
    output logic                                    empty,
    output logic [CNT_W-1:0]                        count
);

    logic [ELEMS_PER_SET-1:0][ACC_WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] rd_nxt;
    logic             push_ok;
    logic             pop_ok;

    assign full     = (count == CNT_W'(DEPTH));
    assign empty    = (count == '0);
    // A push into a full buffer is legal when the head slot is freed on the same edge.
    assign push_ok  = push && (!full || pop);
    assign pop_ok   = pop && !empty;
    assign rd_nxt   = rd_ptr + PTR_W'(1);
    assign head_set = mem[rd_ptr];
    assign next_set = mem[rd_nxt];

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= wr_set;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_nxt;
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/result_drain.sv
// Buffers 2x2 result sets and serializes them c00,c01,c10,c11 onto a valid/ready stream.
// Optional out_parity port is enabled by defining RESULT_DRAIN_PARITY_EN.
module result_drain
    import result_drain_pkg::*;
#(
    parameter int unsigned ACC_WIDTH = ACC_WIDTH_DEF,
    parameter int unsigned DEPTH     = 2
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 in_valid,
    input  logic [ACC_WIDTH-1:0] c00,
    input  logic [ACC_WIDTH-1:0] c01,
    input  logic [ACC_WIDTH-1:0] c10,
    input  logic [ACC_WIDTH-1:0] c11,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [ACC_WIDTH-1:0] out_data,
    output logic [1:0]           out_idx,
    output logic                 out_last,
    output logic                 drop_err
`ifdef RESULT_DRAIN_PARITY_EN
    ,
    output logic                 out_parity
`endif
);

    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    state_t                                  state;
    logic                                    armed;
    logic                                    push;
    logic                                    pop;
    logic                                    fifo_full;
    logic                                    fifo_empty;
    logic                                    more_than_one;
    logic [CNT_W-1:0]                        fifo_count;
    logic [ELEMS_PER_SET-1:0][ACC_WIDTH-1:0] wr_set;
    logic [ELEMS_PER_SET-1:0][ACC_WIDTH-1:0] head_set;
    logic [ELEMS_PER_SET-1:0][ACC_WIDTH-1:0] next_set;
    elem_idx_t                               nxt_idx;

    assign wr_set        = {c11, c10, c01, c00};
    assign pop           = out_valid && out_ready && out_last;
    assign push          = armed && in_valid && (!fifo_full || pop);
    assign more_than_one = (fifo_count > CNT_W'(1));
    assign nxt_idx       = out_idx + 2'd1;

    result_drain_fifo #(
        .ACC_WIDTH (ACC_WIDTH),
        .DEPTH     (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rstn     (rstn),
        .push     (push),
        .pop      (pop),
        .wr_set   (wr_set),
        .head_set (head_set),
        .next_set (next_set),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (fifo_count)
    );

    // Low for exactly the first edge after reset release, so that edge never captures.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            armed <= 1'b0;
        end else begin
            armed <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_idx   <= '0;
            out_last  <= 1'b0;
            drop_err  <= 1'b0;
        end else begin
            if (armed && in_valid && fifo_full && !pop) begin
                drop_err <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (!fifo_empty) begin
                        out_valid <= 1'b1;
                        out_data  <= head_set[0];
                        out_idx   <= '0;
                        out_last  <= 1'b0;
                        state     <= SEND;
                    end
                end
                SEND: begin
                    if (out_ready) begin
                        if (out_last) begin
                            out_idx  <= '0;
                            out_last <= 1'b0;
                            // A set captured on this very edge is not in next_set yet; IDLE picks it up.
                            if (more_than_one) begin
                                out_data <= next_set[0];
                            end else begin
                                out_valid <= 1'b0;
                                state     <= IDLE;
                            end
                        end else begin
                            out_idx  <= nxt_idx;
                            out_data <= head_set[nxt_idx];
                            out_last <= (nxt_idx == 2'd3);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef RESULT_DRAIN_PARITY_EN
    assign out_parity = ^out_data;
`endif

endmodule

// File: tb/tb_result_drain.sv
// Self-checking bench for result_drain: scoreboard monitor plus table and corner-case sequences.
module tb_result_drain;
    import result_drain_pkg::*;

    localparam int unsigned W = 9;
    localparam int unsigned D = 2;

    logic         clk = 1'b0;
    logic         rstn;
    logic         in_valid;
    logic [W-1:0] c00, c01, c10, c11;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;
    logic [1:0]   out_idx;
    logic         out_last;
    logic         drop_err;
`ifdef RESULT_DRAIN_PARITY_EN
    logic         out_parity;
`endif

    always #5 clk = ~clk;

    result_drain #(
        .ACC_WIDTH (W),
        .DEPTH     (D)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .in_valid  (in_valid),
        .c00       (c00),
        .c01       (c01),
        .c10       (c10),
        .c11       (c11),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_idx   (out_idx),
        .out_last  (out_last),
        .drop_err  (drop_err)
`ifdef RESULT_DRAIN_PARITY_EN
        ,
        .out_parity(out_parity)
`endif
    );

    typedef struct packed {
        logic [W-1:0] data;
        logic [1:0]   idx;
        logic         last;
    } elem_t;

    typedef struct {
        logic [W-1:0] c0, c1, c2, c3;
        int unsigned  gap;
        bit           acc;
    } vec_t;

    elem_t        sb[$];
    vec_t         tbl [6];
    logic [W-1:0] ed [4];
    int unsigned  tests = 0;
    int unsigned  fails = 0;
    logic         seen;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    task automatic expect_set(input logic [W-1:0] a, b, c, d);
        sb.push_back('{data: a, idx: 2'd0, last: 1'b0});
        sb.push_back('{data: b, idx: 2'd1, last: 1'b0});
        sb.push_back('{data: c, idx: 2'd2, last: 1'b0});
        sb.push_back('{data: d, idx: 2'd3, last: 1'b1});
    endtask

    task automatic cycles(input int unsigned n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Presents one set for exactly one edge; acc says whether it must be accepted.
    task automatic pulse(input logic [W-1:0] a, b, c, d, input bit acc);
        in_valid = 1'b1;
        c00 = a; c01 = b; c10 = c; c11 = d;
        if (acc) expect_set(a, b, c, d);
        cycles(1);
        in_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        int unsigned k;
        k = 0;
        while ((sb.size() != 0 || out_valid) && k < 200) begin
            cycles(1);
            k++;
        end
        chk(name, 32'(sb.size()), 32'd0);
        chk({name, "_idle"}, 32'(out_valid), 32'd0);
    endtask

    task automatic setv(input int i, input logic [W-1:0] a, b, c, d, input int unsigned g);
        tbl[i].c0 = a; tbl[i].c1 = b; tbl[i].c2 = c; tbl[i].c3 = d;
        tbl[i].gap = g;
        tbl[i].acc = 1'b1;
    endtask

    // Scoreboard monitor plus generic hold-while-stalled checking.
    logic         stalled;
    logic [W-1:0] s_data;
    logic [1:0]   s_idx;
    logic         s_last;

    always @(negedge clk) begin
        if (!rstn) begin
            stalled <= 1'b0;
        end else begin
            if (stalled) begin
                chk("hold_valid", 32'(out_valid), 32'd1);
                chk("hold_data", 32'(out_data), 32'(s_data));
                chk("hold_idx", 32'(out_idx), 32'(s_idx));
                chk("hold_last", 32'(out_last), 32'(s_last));
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_elem: actual data %0h idx %0d, required no element", out_data, out_idx);
                end else begin
                    chk("elem", 32'({out_data, out_idx, out_last}), 32'(sb[0]));
`ifdef RESULT_DRAIN_PARITY_EN
                    chk("parity", 32'(out_parity), 32'(^sb[0].data));
`endif
                    void'(sb.pop_front());
                end
            end
            stalled <= out_valid && !out_ready;
            s_data  <= out_data;
            s_idx   <= out_idx;
            s_last  <= out_last;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: actual timeout, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rstn = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        c00 = '0; c01 = '0; c10 = '0; c11 = '0;
        ed[0] = 9'd5; ed[1] = 9'd17; ed[2] = 9'd200; ed[3] = 9'd511;
        setv(0, 9'h1FF, 9'h003, 9'h000, 9'h155, 0);
        setv(1, 9'h0AA, 9'h100, 9'h001, 9'h0FF, 6);
        setv(2, 9'h003, 9'h1FF, 9'h080, 9'h07F, 3);
        setv(3, 9'h000, 9'h000, 9'h1FE, 9'h002, 6);
        setv(4, 9'h123, 9'h0C3, 9'h1E1, 9'h010, 0);
        setv(5, 9'h1FF, 9'h1FF, 9'h003, 9'h003, 8);

        cycles(2);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_data", 32'(out_data), 32'd0);
        chk("rst_idx", 32'(out_idx), 32'd0);
        chk("rst_last", 32'(out_last), 32'd0);
        chk("rst_drop", 32'(drop_err), 32'd0);

        // First edge after release must not capture.
        rstn = 1'b1;
        pulse(9'h0AA, 9'h0BB, 9'h0CC, 9'h0DD, 1'b0);
        seen = 1'b0;
        repeat (6) begin cycles(1); seen = seen | out_valid; end
        chk("first_edge_ignored", 32'(seen), 32'd0);

        // Single set, four consecutive elements.
        pulse(ed[0], ed[1], ed[2], ed[3], 1'b1);
        chk("early_valid", 32'(out_valid), 32'd0);
        for (int k = 0; k < 4; k++) begin
            cycles(1);
            chk("seq_valid", 32'(out_valid), 32'd1);
            chk("seq_data", 32'(out_data), 32'(ed[k]));
            chk("seq_idx", 32'(out_idx), 32'(k));
            chk("seq_last", 32'(out_last), 32'(k == 3));
        end
        cycles(1);
        chk("seq_end_valid", 32'(out_valid), 32'd0);
        chk("seq_drop", 32'(drop_err), 32'd0);
        drain("seq_drain");

        // Stall for three cycles at idx 1.
        pulse(ed[0], ed[1], ed[2], ed[3], 1'b1);
        cycles(2);
        chk("stall_pre_idx", 32'(out_idx), 32'd1);
        out_ready = 1'b0;
        repeat (3) begin
            cycles(1);
            chk("stall_data", 32'(out_data), 32'd17);
            chk("stall_idx", 32'(out_idx), 32'd1);
        end
        out_ready = 1'b1;
        cycles(1);
        chk("resume_data", 32'(out_data), 32'd200);
        chk("resume_idx", 32'(out_idx), 32'd2);
        drain("stall_drain");

        // Table of sets with assorted gaps, downstream always ready.
        for (int i = 0; i < 6; i++) begin
            pulse(tbl[i].c0, tbl[i].c1, tbl[i].c2, tbl[i].c3, tbl[i].acc);
            cycles(tbl[i].gap);
        end
        drain("table_drain");
        chk("table_drop", 32'(drop_err), 32'd0);

        // Overflow: third back-to-back set is lost.
        out_ready = 1'b0;
        pulse(9'h011, 9'h012, 9'h013, 9'h014, 1'b1);
        pulse(9'h021, 9'h022, 9'h023, 9'h024, 1'b1);
        chk("ovf_no_drop_yet", 32'(drop_err), 32'd0);
        pulse(9'h031, 9'h032, 9'h033, 9'h034, 1'b0);
        chk("ovf_drop", 32'(drop_err), 32'd1);
        cycles(3);
        out_ready = 1'b1;
        drain("ovf_drain");
        chk("ovf_drop_sticky", 32'(drop_err), 32'd1);

        rstn = 1'b0;
        #1;
        chk("rst2_drop", 32'(drop_err), 32'd0);
        cycles(2);
        rstn = 1'b1;
        cycles(1);

        // Full buffer, new set coincides with idx-3 handshake.
        out_ready = 1'b0;
        pulse(9'h041, 9'h042, 9'h043, 9'h044, 1'b1);
        pulse(9'h051, 9'h052, 9'h053, 9'h054, 1'b1);
        cycles(1);
        out_ready = 1'b1;
        cycles(3);
        chk("coinc_idx", 32'(out_idx), 32'd3);
        chk("coinc_last", 32'(out_last), 32'd1);
        pulse(9'h061, 9'h062, 9'h063, 9'h064, 1'b1);
        chk("coinc_drop", 32'(drop_err), 32'd0);
        drain("coinc_drain");
        chk("coinc_drop_end", 32'(drop_err), 32'd0);

        // Reset mid-set at idx 2 with one set queued.
        out_ready = 1'b0;
        pulse(9'h071, 9'h072, 9'h073, 9'h074, 1'b1);
        pulse(9'h081, 9'h082, 9'h083, 9'h084, 1'b1);
        cycles(1);
        out_ready = 1'b1;
        cycles(2);
        out_ready = 1'b0;
        chk("mid_idx", 32'(out_idx), 32'd2);
        rstn = 1'b0;
        #1;
        sb.delete();
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_data", 32'(out_data), 32'd0);
        chk("mid_rst_idx", 32'(out_idx), 32'd0);
        chk("mid_rst_last", 32'(out_last), 32'd0);
        out_ready = 1'b1;
        cycles(2);
        rstn = 1'b1;
        cycles(1);
        seen = 1'b0;
        repeat (8) begin cycles(1); seen = seen | out_valid; end
        chk("no_emit_after_rst", 32'(seen), 32'd0);
        pulse(9'h091, 9'h092, 9'h093, 9'h094, 1'b1);
        drain("post_rst_drain");
        chk("post_rst_drop", 32'(drop_err), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
